// File: rtl/accumulator_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : accumulator_sequencer
// Purpose  : Moore control FSM for a 16-bit accumulator CPU (fetch/decode/exec)
// Revision : 1.0 - initial release
// ============================================================================
module accumulator_sequencer #(
  parameter bit AUTO_RUN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        acc_zero,
  input  logic        acc_neg,
  output logic        pc_write,
  output logic        mar_write,
  output logic        mbr_write,
  output logic        ir_write,
  output logic        acc_write,
  output logic        pc_sel,
  output logic        mar_sel,
  output logic        mbr_sel,
  output logic [1:0]  acc_sel,
  output logic [3:0]  alu_op,
  output logic        mem_write,
  output logic        retire,
  output logic        halted,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    F_ADDR  = 4'd1,
    F_MEM   = 4'd2,
    F_IR    = 4'd3,
    DECODE  = 4'd4,
    M_READ  = 4'd5,
    M_MBR   = 4'd6,
    EXEC    = 4'd7,
    S_MBR   = 4'd8,
    S_WRITE = 4'd9,
    HALTED  = 4'd10
  } state_t;

  state_t     r_state;
  logic [3:0] w_opcode;
  logic       w_go;
  logic       w_mem_operand;
  logic       w_unused_addr;

  assign w_opcode      = ir[15:12];
  assign w_go          = run | AUTO_RUN;
  assign w_mem_operand = (w_opcode == 4'h0) || ((w_opcode >= 4'h2) && (w_opcode <= 4'h6));
  // The address field is routed by the datapath muxes, not by this block.
  assign w_unused_addr = ^ir[11:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    r_state <= w_go ? F_ADDR : IDLE;
        F_ADDR:  r_state <= F_MEM;
        F_MEM:   r_state <= F_IR;
        F_IR:    r_state <= DECODE;
        DECODE: begin
          if (w_mem_operand)          r_state <= M_READ;
          else if (w_opcode == 4'h1)  r_state <= S_MBR;
          else if (w_opcode == 4'hF)  r_state <= HALTED;
          else                        r_state <= w_go ? F_ADDR : IDLE;
        end
        M_READ:  r_state <= M_MBR;
        M_MBR:   r_state <= EXEC;
        EXEC:    r_state <= w_go ? F_ADDR : IDLE;
        S_MBR:   r_state <= S_WRITE;
        S_WRITE: r_state <= w_go ? F_ADDR : IDLE;
        HALTED:  r_state <= HALTED;
        default: r_state <= IDLE;
      endcase
    end
  end

  // DECODE and EXEC outputs follow the opcode held in IR for this instruction.
  always_comb begin
    pc_write  = 1'b0;
    mar_write = 1'b0;
    mbr_write = 1'b0;
    ir_write  = 1'b0;
    acc_write = 1'b0;
    pc_sel    = 1'b0;
    mar_sel   = 1'b0;
    mbr_sel   = 1'b0;
    acc_sel   = 2'b00;
    alu_op    = 4'b0000;
    mem_write = 1'b0;
    retire    = 1'b0;
    case (r_state)
      F_ADDR: mar_write = 1'b1;
      F_MEM:  pc_write  = 1'b1;
      F_IR:   ir_write  = 1'b1;
      DECODE: begin
        case (w_opcode)
          4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
            mar_write = 1'b1;
            mar_sel   = 1'b1;
          end
          4'h7, 4'h8: begin
            acc_write = 1'b1;
            alu_op    = (w_opcode == 4'h7) ? 4'b0100 : 4'b0101;
            retire    = 1'b1;
          end
          4'h9, 4'hA, 4'hB: begin
            pc_write = (w_opcode == 4'h9) || (w_opcode == 4'hA && acc_zero) ||
                       (w_opcode == 4'hB && acc_neg);
            pc_sel   = pc_write;
            retire   = 1'b1;
          end
          4'hC: begin
            acc_write = 1'b1;
            acc_sel   = 2'b10;
            retire    = 1'b1;
          end
          default: retire = 1'b1;
        endcase
      end
      M_MBR: mbr_write = 1'b1;
      EXEC: begin
        acc_write = 1'b1;
        retire    = 1'b1;
        case (w_opcode)
          4'h0:    acc_sel = 2'b01;
          4'h3:    alu_op  = 4'b0001;
          4'h4:    alu_op  = 4'b1000;
          4'h5:    alu_op  = 4'b1001;
          4'h6:    alu_op  = 4'b1010;
          default: alu_op  = 4'b0000;
        endcase
      end
      S_MBR: begin
        mbr_write = 1'b1;
        mbr_sel   = 1'b1;
      end
      S_WRITE: begin
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = (r_state == HALTED);
  assign state  = r_state;

endmodule
`default_nettype wire

// File: doc/accumulator_sequencer.md
ACCUMULATOR_SEQUENCER -- requirements
Module: accumulator_sequencer

Interface
REQ-001 The block SHALL have parameter AUTO_RUN, default 0, meaning that when 1, IDLE is left on the first clock after reset regardless of run.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  asynchronous, active-high reset
- run  in  1  start / continue request, level-sensitive
- ir  in  16  current IR contents; opcode = ir[15:12], address = ir[11:0]
- acc_zero  in  1  ACC == 0
- acc_neg  in  1  ACC[15]
- pc_write, mar_write, mbr_write, ir_write, acc_write  out  1 each  register write enables
- pc_sel  out  1  0 = PC+1, 1 = {4'b0, ir[11:0]}
- mar_sel  out  1  0 = PC, 1 = {4'b0, ir[11:0]}
- mbr_sel  out  1  0 = memory data_out, 1 = ACC
- acc_sel  out  2  00 = ALU result, 01 = MBR, 10 = zero
- alu_op  out  4  ALU operation code
- mem_write  out  1  main-memory write enable
- retire  out  1  one-cycle pulse on the last cycle of each instruction
- halted  out  1  high while in HALTED
- state  out  4  current state encoding, for debug

Function
REQ-003 The block SHALL be a Moore FSM with exactly these states: IDLE=0, F_ADDR=1, F_MEM=2, F_IR=3, DECODE=4, M_READ=5, M_MBR=6, EXEC=7, S_MBR=8, S_WRITE=9, HALTED=10.
REQ-004 The block SHALL hold all write enables, mem_write and retire at 0 in any state where this document does not assert them.
REQ-005 The transition from IDLE SHALL go to F_ADDR when run=1 or AUTO_RUN=1, and otherwise stay in IDLE.
REQ-006 In F_ADDR the block SHALL drive mar_write=1 and mar_sel=0, then go to F_MEM.
REQ-007 In F_MEM the block SHALL drive pc_write=1 and pc_sel=0, covering the one-cycle synchronous memory read, then go to F_IR; PC wraps 16'hFFFF -> 16'h0000 without a flag.
REQ-008 In F_IR the block SHALL drive ir_write=1 (IR is loaded from memory data_out), then go to DECODE.
REQ-009 DECODE SHALL act on the opcode as follows:
- 0 LOAD, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: mar_write=1, mar_sel=1, go to M_READ.
- 1 STORE: mar_write=1, mar_sel=1, go to S_MBR.
- 7 SHL / 8 SHR: acc_write=1, acc_sel=00, alu_op=0100 / 0101, retire.
- 9 JUMP: pc_write=1, pc_sel=1, retire.
- A JZ: same as JUMP when acc_zero=1, otherwise retire with no write.
- B JN: same as JUMP when acc_neg=1, otherwise retire with no write.
- C CLEAR: acc_write=1, acc_sel=10, retire.
- F HALT: retire, go to HALTED.
- D, E (NOP): retire only.
REQ-010 M_READ SHALL be an idle wait cycle for the memory read latency and SHALL go to M_MBR.
REQ-011 In M_MBR the block SHALL drive mbr_write=1 and mbr_sel=0, then go to EXEC.
REQ-012 In EXEC the block SHALL drive acc_write=1 and retire=1; LOAD uses acc_sel=01; ADD/SUB/AND/OR/XOR use acc_sel=00 with alu_op 0000/0001/1000/1001/1010.
REQ-013 In S_MBR the block SHALL drive mbr_write=1 and mbr_sel=1, then go to S_WRITE.
REQ-014 In S_WRITE the block SHALL drive mem_write=1 and retire=1.
REQ-015 Instruction latency SHALL be: memory-operand ALU/LOAD 7 cycles, STORE 6 cycles, all others 4 cycles.
REQ-016 After any retire other than HALT, the next state SHALL be F_ADDR when run=1 or AUTO_RUN=1, and otherwise IDLE; dropping run mid-instruction never aborts that instruction.
REQ-017 HALTED SHALL be absorbing until reset, with halted=1 and run ignored.
REQ-018 alu_op SHALL be 0000 in every state where it is not specified above.

Reset
REQ-019 Asserting reset SHALL force IDLE immediately and drive all outputs to 0, including state=0 and halted=0, in any state (including mid-STORE, where mem_write drops at once).
REQ-020 The first transition SHALL evaluate on the first rising clk edge after reset deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- reset, run=1, memory[0]=16'h0005 (LOAD 5), memory[5]=16'h1234 -> state sequence 1,2,3,4,5,6,7; acc_write with acc_sel=01 in cycle 7; retire pulses once.
- ADD 16'h2006 -> alu_op=0000 and acc_sel=00 in EXEC; 7 cycles from F_ADDR to retire.
- STORE 16'h1010 -> mar_sel=1 in DECODE, mbr_sel=1 in S_MBR, mem_write=1 for exactly one cycle; 6 cycles.
- JZ 16'hA020 with acc_zero=0 then acc_zero=1 -> no pc_write, then pc_write=1 with pc_sel=1; 4 cycles each.
- HALT 16'hF000 -> halted=1 and state=10 held for 20 cycles with run toggling; run=0 during an ADD -> retire, then IDLE.
- reset asserted in S_WRITE -> mem_write=0 and state=0 before the next clk edge.
